// File: rtl/mem_stage_hs.sv
// Pipeline memory stage: req/gnt/rvalid handshake to variable-latency data memory,
// byte-lane steering, load extension, misalign/illegal detection and access timeout.
module mem_stage_hs #(
  parameter int          ADDR_W      = 32,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] PC_INC      = 32'd4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ex_vld,
  output logic              o_ex_rdy,
  input  logic [31:0]       i_ex_pc,
  input  logic [31:0]       i_ex_inst,
  input  logic [31:0]       i_ex_alu_data,
  input  logic [31:0]       i_ex_rs2_data,
  input  logic              i_ex_lsu_rden,
  input  logic              i_ex_lsu_wren,
  input  logic [2:0]        i_ex_funct3,
  input  logic [1:0]        i_ex_wb_sel,
  input  logic              i_ex_rd_wren,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_be,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [31:0]       i_dmem_rdata,
  output logic              o_wb_vld,
  output logic [31:0]       o_wb_pc_add4,
  output logic [31:0]       o_wb_alu_data,
  output logic [31:0]       o_wb_ld_data,
  output logic [31:0]       o_wb_inst,
  output logic [1:0]        o_wb_wb_sel,
  output logic              o_wb_rd_wren,
  output logic [4:0]        o_mem_rd_addr_fwd,
  output logic              o_mem_stall,
  output logic              o_misalign,
  output logic              o_timeout
);

  // state | meaning
  // IDLE  | ready for a new instruction; non-memory ops and faults retire from here
  // REQ   | o_dmem_req held with stable address/data until i_dmem_gnt
  // RESP  | load granted, waiting for i_dmem_rvalid
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] pc_q, pc_d, inst_q, inst_d, alu_q, alu_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic        rden_q, rden_d, wren_q, wren_d, rd_wren_q, rd_wren_d;
  logic [1:0]  wb_sel_q, wb_sel_d;

  logic        wb_vld_q, wb_vld_d, wb_rd_wren_q, wb_rd_wren_d;
  logic [31:0] wb_pc_add4_q, wb_pc_add4_d, wb_alu_q, wb_alu_d;
  logic [31:0] wb_ld_q, wb_ld_d, wb_inst_q, wb_inst_d;
  logic [1:0]  wb_wb_sel_q, wb_wb_sel_d;
  logic        misalign_q, misalign_d, timeout_q, timeout_d;

  logic        mem_op, illegal, misal, fault, accept;
  logic        complete_st, complete_ld, completion, tmo_hit;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pc_q         <= '0;
      inst_q       <= '0;
      alu_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      f3_q         <= '0;
      rden_q       <= 1'b0;
      wren_q       <= 1'b0;
      rd_wren_q    <= 1'b0;
      wb_sel_q     <= '0;
      wb_vld_q     <= 1'b0;
      wb_pc_add4_q <= '0;
      wb_alu_q     <= '0;
      wb_ld_q      <= '0;
      wb_inst_q    <= '0;
      wb_wb_sel_q  <= '0;
      wb_rd_wren_q <= 1'b0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      f3_q         <= f3_d;
      rden_q       <= rden_d;
      wren_q       <= wren_d;
      rd_wren_q    <= rd_wren_d;
      wb_sel_q     <= wb_sel_d;
      wb_vld_q     <= wb_vld_d;
      wb_pc_add4_q <= wb_pc_add4_d;
      wb_alu_q     <= wb_alu_d;
      wb_ld_q      <= wb_ld_d;
      wb_inst_q    <= wb_inst_d;
      wb_wb_sel_q  <= wb_wb_sel_d;
      wb_rd_wren_q <= wb_rd_wren_d;
      misalign_q   <= misalign_d;
      timeout_q    <= timeout_d;
    end
  end

  // Decode, lane precompute and next-state
  always_comb begin
    mem_op  = i_ex_lsu_rden | i_ex_lsu_wren;
    illegal = (i_ex_lsu_rden & i_ex_lsu_wren)
            | (i_ex_lsu_rden & ((i_ex_funct3 == 3'b011) | (i_ex_funct3 == 3'b110) |
                                (i_ex_funct3 == 3'b111)))
            | (i_ex_lsu_wren & (i_ex_funct3 > 3'b010));
    misal   = ((i_ex_funct3[1:0] == 2'b01) & i_ex_alu_data[0])
            | ((i_ex_funct3[1:0] == 2'b10) & (|i_ex_alu_data[1:0]));
    fault   = mem_op & (illegal | misal);
    accept  = (state_q == S_IDLE) & i_ex_vld;

    be_in    = 4'b1111;
    wdata_in = i_ex_rs2_data;
    case (i_ex_funct3[1:0])
      2'b00: begin
        wdata_in = {4{i_ex_rs2_data[7:0]}};
        if (i_ex_lsu_wren) be_in = 4'b0001 << i_ex_alu_data[1:0];
      end
      2'b01: begin
        wdata_in = {2{i_ex_rs2_data[15:0]}};
        if (i_ex_lsu_wren) be_in = i_ex_alu_data[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase

    pc_d      = pc_q;
    inst_d    = inst_q;
    alu_d     = alu_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    f3_d      = f3_q;
    rden_d    = rden_q;
    wren_d    = wren_q;
    rd_wren_d = rd_wren_q;
    wb_sel_d  = wb_sel_q;
    if (accept) begin
      pc_d      = i_ex_pc;
      inst_d    = i_ex_inst;
      alu_d     = i_ex_alu_data;
      wdata_d   = wdata_in;
      be_d      = be_in;
      f3_d      = i_ex_funct3;
      rden_d    = i_ex_lsu_rden;
      wren_d    = i_ex_lsu_wren;
      rd_wren_d = i_ex_rd_wren;
      wb_sel_d  = i_ex_wb_sel;
    end

    complete_st = (state_q == S_REQ) & i_dmem_gnt & wren_q;
    complete_ld = (state_q == S_RESP) & i_dmem_rvalid;
    completion  = complete_st | complete_ld;
    // A load grant on the last cycle is not a completion, so it still times out
    tmo_hit     = (state_q != S_IDLE) & (cnt_q == CNT_LAST) & ~completion;

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept & mem_op & ~fault) state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit)         state_d = S_IDLE;
        else if (i_dmem_gnt) state_d = wren_q ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tmo_hit | i_dmem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load extension and writeback register
  always_comb begin
    ld_byte = i_dmem_rdata[{alu_q[1:0], 3'b000} +: 8];
    ld_half = alu_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = i_dmem_rdata;
    endcase

    wb_vld_d     = 1'b0;
    misalign_d   = 1'b0;
    timeout_d    = 1'b0;
    wb_pc_add4_d = wb_pc_add4_q;
    wb_alu_d     = wb_alu_q;
    wb_ld_d      = wb_ld_q;
    wb_inst_d    = wb_inst_q;
    wb_wb_sel_d  = wb_wb_sel_q;
    wb_rd_wren_d = wb_rd_wren_q;
    if (accept & (~mem_op | fault)) begin
      wb_vld_d     = 1'b1;
      misalign_d   = fault;
      wb_pc_add4_d = i_ex_pc + PC_INC;
      wb_alu_d     = i_ex_alu_data;
      wb_ld_d      = '0;
      wb_inst_d    = i_ex_inst;
      wb_wb_sel_d  = i_ex_wb_sel;
      wb_rd_wren_d = i_ex_rd_wren & ~fault;
    end else if (completion | tmo_hit) begin
      wb_vld_d     = 1'b1;
      timeout_d    = tmo_hit;
      wb_pc_add4_d = pc_q + PC_INC;
      wb_alu_d     = alu_q;
      wb_ld_d      = complete_ld ? ld_ext : '0;
      wb_inst_d    = inst_q;
      wb_wb_sel_d  = wb_sel_q;
      wb_rd_wren_d = rd_wren_q & ~tmo_hit;
    end
  end

  assign o_mem_stall       = (state_q != S_IDLE);
  assign o_ex_rdy          = ~o_mem_stall & i_reset;
  assign o_dmem_req        = (state_q == S_REQ);
  assign o_dmem_we         = wren_q;
  assign o_dmem_addr       = {alu_q[ADDR_W-1:2], 2'b00};
  assign o_dmem_wdata      = wdata_q;
  assign o_dmem_be         = be_q;
  assign o_mem_rd_addr_fwd = o_mem_stall ? inst_q[11:7] : i_ex_inst[11:7];

  assign o_wb_vld      = wb_vld_q;
  assign o_wb_pc_add4  = wb_pc_add4_q;
  assign o_wb_alu_data = wb_alu_q;
  assign o_wb_ld_data  = wb_ld_q;
  assign o_wb_inst     = wb_inst_q;
  assign o_wb_wb_sel   = wb_wb_sel_q;
  assign o_wb_rd_wren  = wb_rd_wren_q;
  assign o_misalign    = misalign_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_mem_stage_hs;
  localparam int TMO = 8;

  logic        i_clk = 1'b0;
  logic        i_reset, i_ex_vld, o_ex_rdy;
  logic [31:0] i_ex_pc, i_ex_inst, i_ex_alu_data, i_ex_rs2_data;
  logic        i_ex_lsu_rden, i_ex_lsu_wren, i_ex_rd_wren;
  logic [2:0]  i_ex_funct3;
  logic [1:0]  i_ex_wb_sel;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_vld, o_wb_rd_wren, o_mem_stall, o_misalign, o_timeout;
  logic [31:0] o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data, o_wb_inst;
  logic [1:0]  o_wb_wb_sel;
  logic [4:0]  o_mem_rd_addr_fwd;

  int n_pass = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  mem_stage_hs #(.ADDR_W(32), .TIMEOUT_CYC(TMO), .PC_INC(32'd4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ex_vld(i_ex_vld), .o_ex_rdy(o_ex_rdy),
    .i_ex_pc(i_ex_pc), .i_ex_inst(i_ex_inst), .i_ex_alu_data(i_ex_alu_data),
    .i_ex_rs2_data(i_ex_rs2_data), .i_ex_lsu_rden(i_ex_lsu_rden),
    .i_ex_lsu_wren(i_ex_lsu_wren), .i_ex_funct3(i_ex_funct3), .i_ex_wb_sel(i_ex_wb_sel),
    .i_ex_rd_wren(i_ex_rd_wren), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_vld(o_wb_vld), .o_wb_pc_add4(o_wb_pc_add4), .o_wb_alu_data(o_wb_alu_data),
    .o_wb_ld_data(o_wb_ld_data), .o_wb_inst(o_wb_inst), .o_wb_wb_sel(o_wb_wb_sel),
    .o_wb_rd_wren(o_wb_rd_wren), .o_mem_rd_addr_fwd(o_mem_rd_addr_fwd),
    .o_mem_stall(o_mem_stall), .o_misalign(o_misalign), .o_timeout(o_timeout)
  );

  // Reference: is a memory access illegal or misaligned
  function automatic logic ref_fault(input logic rden, input logic wren,
                                     input logic [2:0] f3, input logic [1:0] a);
    int sz;
    if (rden && wren) return 1'b1;
    if (rden && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (wren && f3 > 2) return 1'b1;
    sz = 1 << f3[1:0];
    return (int'(a) % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * int'(a))) & 32'hFF;
    h = (rdata >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'h80) ? b - 32'h100 : b;
      3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return rdata;
    endcase
  endfunction

  task automatic idle_inputs();
    i_ex_vld = 0; i_ex_lsu_rden = 0; i_ex_lsu_wren = 0;
    i_ex_pc = $urandom; i_ex_inst = $urandom; i_ex_alu_data = $urandom;
    i_ex_rs2_data = $urandom; i_ex_funct3 = 3'($urandom); i_ex_wb_sel = 2'($urandom);
    i_ex_rd_wren = 1'($urandom); i_dmem_gnt = 0; i_dmem_rvalid = 0;
  endtask

  // Drives one instruction and the memory side; g = gnt wait cycles, r = rvalid wait (-1 never)
  task automatic run_txn(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic rden,
                         input logic wren, input logic [2:0] f3, input logic [1:0] wbsel,
                         input logic rdw, input int g, input int r, input logic [31:0] rdata,
                         input logic spur);
    logic mem, fault, load, tmo;
    int last;
    logic [31:0] exp_ld, exp_wd;
    logic [3:0] exp_be;
    mem = rden | wren;
    fault = mem && ref_fault(rden, wren, f3, alu[1:0]);
    load = rden & ~wren;
    tmo = 0; last = 0;
    if (mem && !fault) begin
      if (wren) begin
        if (g + 1 <= TMO) last = g + 1; else begin last = TMO; tmo = 1; end
      end else if (g + 1 >= TMO || r < 0 || g + r + 2 > TMO) begin
        last = TMO; tmo = 1;
      end else last = g + r + 2;
    end
    exp_ld = (load && !fault && !tmo) ? ref_load(f3, alu[1:0], rdata) : 32'h0;
    exp_be = 4'hF; exp_wd = rs2;
    if (f3[1:0] == 0) begin
      exp_wd = {4{rs2[7:0]}};
      if (wren) exp_be = 4'(1 << alu[1:0]);
    end else if (f3[1:0] == 1) begin
      exp_wd = {2{rs2[15:0]}};
      if (wren) exp_be = 4'(3 << (alu[1:0] & 2'b10));
    end

    i_ex_vld = 1; i_ex_pc = pc; i_ex_inst = inst; i_ex_alu_data = alu; i_ex_rs2_data = rs2;
    i_ex_lsu_rden = rden; i_ex_lsu_wren = wren; i_ex_funct3 = f3; i_ex_wb_sel = wbsel;
    i_ex_rd_wren = rdw; i_dmem_gnt = 0; i_dmem_rvalid = spur; i_dmem_rdata = rdata;
    @(negedge i_clk);
    n_total++; if (o_ex_rdy !== 1'b1) $display("FAIL %s issue_rdy got=%b exp=1", tag, o_ex_rdy); else n_pass++;
    n_total++; if (o_mem_rd_addr_fwd !== inst[11:7]) $display("FAIL %s issue_fwd got=%0d exp=%0d", tag, o_mem_rd_addr_fwd, inst[11:7]); else n_pass++;
    @(posedge i_clk); #1;
    idle_inputs(); i_dmem_rdata = rdata;
    for (int k = 1; k <= last; k++) begin
      i_dmem_gnt = (k == g + 1);
      i_dmem_rvalid = (spur && k <= g + 1) || (load && r >= 0 && k == g + r + 2);
      @(negedge i_clk);
      n_total++; if (o_mem_stall !== 1'b1 || o_ex_rdy !== 1'b0) $display("FAIL %s stall k=%0d got stall=%b rdy=%b exp stall=1 rdy=0", tag, k, o_mem_stall, o_ex_rdy); else n_pass++;
      n_total++; if (o_wb_vld !== 1'b0) $display("FAIL %s early_wb k=%0d got=%b exp=0", tag, k, o_wb_vld); else n_pass++;
      n_total++; if (o_mem_rd_addr_fwd !== inst[11:7]) $display("FAIL %s held_fwd k=%0d got=%0d exp=%0d", tag, k, o_mem_rd_addr_fwd, inst[11:7]); else n_pass++;
      n_total++; if (o_dmem_req !== (k <= g + 1)) $display("FAIL %s req k=%0d got=%b exp=%b", tag, k, o_dmem_req, (k <= g + 1)); else n_pass++;
      if (k <= g + 1) begin
        n_total++;
        if (o_dmem_addr !== {alu[31:2], 2'b00} || o_dmem_we !== wren || o_dmem_be !== exp_be ||
            (wren && o_dmem_wdata !== exp_wd))
          $display("FAIL %s bus k=%0d got addr=%h we=%b be=%b wd=%h exp addr=%h we=%b be=%b wd=%h",
                   tag, k, o_dmem_addr, o_dmem_we, o_dmem_be, o_dmem_wdata,
                   {alu[31:2], 2'b00}, wren, exp_be, exp_wd);
        else n_pass++;
      end
      @(posedge i_clk); #1;
    end
    i_dmem_gnt = 0; i_dmem_rvalid = 0;
    @(negedge i_clk);
    n_total++; if (o_wb_vld !== 1'b1 || o_mem_stall !== 1'b0 || o_ex_rdy !== 1'b1) $display("FAIL %s retire got vld=%b stall=%b rdy=%b exp 1 0 1", tag, o_wb_vld, o_mem_stall, o_ex_rdy); else n_pass++;
    n_total++; if (o_wb_pc_add4 !== pc + 4 || o_wb_alu_data !== alu || o_wb_inst !== inst || o_wb_wb_sel !== wbsel) $display("FAIL %s wb_fields got pc4=%h alu=%h inst=%h sel=%0d exp %h %h %h %0d", tag, o_wb_pc_add4, o_wb_alu_data, o_wb_inst, o_wb_wb_sel, pc + 4, alu, inst, wbsel); else n_pass++;
    n_total++; if (o_wb_rd_wren !== (rdw & ~fault & ~tmo)) $display("FAIL %s rd_wren got=%b exp=%b", tag, o_wb_rd_wren, rdw & ~fault & ~tmo); else n_pass++;
    n_total++; if (o_misalign !== fault || o_timeout !== tmo) $display("FAIL %s flags got mis=%b tmo=%b exp mis=%b tmo=%b", tag, o_misalign, o_timeout, fault, tmo); else n_pass++;
    if (load || fault || tmo) begin
      n_total++; if (o_wb_ld_data !== exp_ld) $display("FAIL %s ld_data got=%h exp=%h", tag, o_wb_ld_data, exp_ld); else n_pass++;
    end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    n_total++; if (o_wb_vld !== 1'b0 || o_misalign !== 1'b0 || o_timeout !== 1'b0) $display("FAIL %s pulse_len got vld=%b mis=%b tmo=%b exp 0 0 0", tag, o_wb_vld, o_misalign, o_timeout); else n_pass++;
    n_total++; if (o_wb_alu_data !== alu || o_wb_inst !== inst) $display("FAIL %s wb_hold got alu=%h inst=%h exp %h %h", tag, o_wb_alu_data, o_wb_inst, alu, inst); else n_pass++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_reset = 0; idle_inputs(); i_dmem_rdata = 0;
    repeat (2) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    n_total++; if (o_ex_rdy !== 1'b0) $display("FAIL reset_rdy got=%b exp=0", o_ex_rdy); else n_pass++;
    n_total++;
    if ({o_wb_vld, o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data, o_wb_inst, o_wb_wb_sel, o_wb_rd_wren,
         o_mem_stall, o_misalign, o_timeout, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata} !== '0)
      $display("FAIL reset_zero got vld=%b pc4=%h alu=%h stall=%b req=%b exp all 0", o_wb_vld, o_wb_pc_add4, o_wb_alu_data, o_mem_stall, o_dmem_req);
    else n_pass++;
    @(posedge i_clk); #1;
    i_reset = 1;
    @(negedge i_clk);
    n_total++; if (o_ex_rdy !== 1'b1) $display("FAIL reset_release_rdy got=%b exp=1", o_ex_rdy); else n_pass++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_alu_op();
    run_txn("alu", 32'h100, 32'h0000_0393, 32'h55, 32'h0, 0, 0, 3'd0, 2'd0, 1, 0, 0, 32'h0, 0);
    n_total++; if (o_wb_pc_add4 !== 32'h104 || o_wb_alu_data !== 32'h55) $display("FAIL alu_plan got pc4=%h alu=%h exp 104 55", o_wb_pc_add4, o_wb_alu_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs[6], alus[6];
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        pcs[i] = $urandom; alus[i] = $urandom;
        i_ex_vld = 1; i_ex_pc = pcs[i]; i_ex_alu_data = alus[i]; i_ex_inst = $urandom;
        i_ex_lsu_rden = 0; i_ex_lsu_wren = 0; i_ex_rd_wren = 1;
      end else idle_inputs();
      @(negedge i_clk);
      n_total++; if (o_ex_rdy !== 1'b1) $display("FAIL b2b_rdy i=%0d got=%b exp=1", i, o_ex_rdy); else n_pass++;
      if (i > 0) begin
        n_total++;
        if (o_wb_vld !== 1'b1 || o_wb_pc_add4 !== pcs[i-1] + 4 || o_wb_alu_data !== alus[i-1])
          $display("FAIL b2b_wb i=%0d got vld=%b pc4=%h alu=%h exp 1 %h %h", i, o_wb_vld, o_wb_pc_add4, o_wb_alu_data, pcs[i-1] + 4, alus[i-1]);
        else n_pass++;
      end
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_lb();
    run_txn("lb", 32'h300, 32'h0000_0283, 32'h203, 32'h0, 1, 0, 3'd0, 2'd1, 1, 2, 0, 32'h80FF_FFFF, 0);
    n_total++; if (o_wb_ld_data !== 32'hFFFF_FF80 || o_dmem_addr !== 32'h200) $display("FAIL lb_plan got ld=%h addr=%h exp FFFFFF80 200", o_wb_ld_data, o_dmem_addr); else n_pass++;
  endtask

  task automatic test_sh();
    run_txn("sh", 32'h400, 32'h0000_1023, 32'h102, 32'h1234_ABCD, 0, 1, 3'd1, 2'd0, 0, 0, 0, 32'h0, 0);
    n_total++; if (o_dmem_be !== 4'b1100 || o_dmem_wdata !== 32'hABCD_ABCD || o_dmem_we !== 1'b1) $display("FAIL sh_plan got be=%b wd=%h we=%b exp 1100 ABCDABCD 1", o_dmem_be, o_dmem_wdata, o_dmem_we); else n_pass++;
  endtask

  task automatic test_misalign();
    run_txn("lw_mis", 32'h500, 32'h0000_2503, 32'h101, 32'h0, 1, 0, 3'd2, 2'd1, 1, 0, 0, 32'hDEAD_BEEF, 0);
    n_total++; if (o_wb_rd_wren !== 1'b0) $display("FAIL mis_plan got rd_wren=%b exp=0", o_wb_rd_wren); else n_pass++;
    run_txn("sw_ill", 32'h504, 32'h0000_3023, 32'h100, 32'h1, 0, 1, 3'd3, 2'd0, 1, 0, 0, 32'h0, 0);
    run_txn("rdwr", 32'h508, 32'h0000_0583, 32'h100, 32'h1, 1, 1, 3'd2, 2'd1, 1, 0, 0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    run_txn("lhu_tmo", 32'h600, 32'h0000_5603, 32'h302, 32'h0, 1, 0, 3'd5, 2'd1, 1, 0, -1, 32'h1234_5678, 0);
    n_total++; if (o_wb_rd_wren !== 1'b0 || o_ex_rdy !== 1'b1) $display("FAIL tmo_plan got rd_wren=%b rdy=%b exp 0 1", o_wb_rd_wren, o_ex_rdy); else n_pass++;
    run_txn("ld_edge", 32'h610, 32'h0000_0683, 32'h400, 32'h0, 1, 0, 3'd2, 2'd1, 1, 3, 3, 32'hCAFE_F00D, 1);
    run_txn("sw_edge", 32'h620, 32'h0000_2023, 32'h404, 32'h7, 0, 1, 3'd2, 2'd0, 0, 7, 0, 32'h0, 0);
    run_txn("ld_gnt_late", 32'h630, 32'h0000_0703, 32'h408, 32'h0, 1, 0, 3'd2, 2'd1, 1, 7, 0, 32'h1, 0);
  endtask

  task automatic test_random();
    logic rden, wren; logic [2:0] f3; logic [31:0] alu; int kind, r;
    logic [2:0] ld_ok[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      rden = (kind >= 2 && kind <= 5) || kind == 9;
      wren = kind >= 6;
      f3 = 3'($urandom);
      if (rden && !wren && $urandom_range(0, 4) != 0) f3 = ld_ok[$urandom_range(0, 4)];
      if (wren && !rden && $urandom_range(0, 4) != 0) f3 = 3'($urandom_range(0, 2));
      alu = $urandom;
      if ($urandom_range(0, 1) == 1) alu = alu & ~((32'd1 << f3[1:0]) - 1);
      r = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      run_txn("rand", $urandom, $urandom, alu, $urandom, rden, wren, f3, 2'($urandom),
              1'($urandom), int'($urandom_range(0, 3)), r, $urandom, 1'($urandom));
    end
  endtask

  task automatic test_reset_in_resp();
    i_ex_vld = 1; i_ex_pc = 32'h700; i_ex_inst = 32'h0000_2783; i_ex_alu_data = 32'h800;
    i_ex_lsu_rden = 1; i_ex_lsu_wren = 0; i_ex_funct3 = 3'd2; i_ex_rd_wren = 1;
    i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 32'h1111_2222;
    @(posedge i_clk); #1;
    idle_inputs(); i_dmem_gnt = 1;
    @(posedge i_clk); #1;
    i_dmem_gnt = 0; i_reset = 0;
    @(negedge i_clk);
    n_total++; if (o_ex_rdy !== 1'b0 || o_mem_stall !== 1'b1) $display("FAIL rst_resp_pre got rdy=%b stall=%b exp 0 1", o_ex_rdy, o_mem_stall); else n_pass++;
    @(posedge i_clk); #1;
    i_reset = 1; i_dmem_rvalid = 1;
    @(negedge i_clk);
    n_total++; if (o_ex_rdy !== 1'b1 || o_mem_stall !== 1'b0) $display("FAIL rst_resp_rdy got rdy=%b stall=%b exp 1 0", o_ex_rdy, o_mem_stall); else n_pass++;
    n_total++;
    if ({o_wb_vld, o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data, o_wb_inst, o_wb_wb_sel, o_wb_rd_wren,
         o_misalign, o_timeout, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata} !== '0)
      $display("FAIL rst_resp_zero got vld=%b pc4=%h alu=%h ld=%h req=%b addr=%h exp all 0", o_wb_vld, o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data, o_dmem_req, o_dmem_addr);
    else n_pass++;
    @(posedge i_clk); #1;
    i_dmem_rvalid = 0;
    @(negedge i_clk);
    n_total++; if (o_wb_vld !== 1'b0 || o_mem_stall !== 1'b0) $display("FAIL rst_resp_ignored got vld=%b stall=%b exp 0 0", o_wb_vld, o_mem_stall); else n_pass++;
    @(posedge i_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_op();
    test_back_to_back();
    test_lb();
    test_sh();
    test_misalign();
    test_timeout();
    test_random();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Next-generation pipeline memory stage. Sits between the EX/MEM register and writeback.
- Replaces the fixed single-cycle LSU access with a req/gnt/rvalid handshake to a variable-latency data memory.
- Stalls the upstream pipeline while an access is outstanding; performs byte-lane steering and load extension.
- Flags misaligned or illegal accesses and memory timeouts instead of silently completing them.

Parameters:
ADDR_W, 32, width of o_dmem_addr (low ADDR_W bits of the ALU result)
TIMEOUT_CYC, 255, cycles spent in REQ+RESP before an access is aborted (>=2)
PC_INC, 4, increment added to the PC to form the link value

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-low reset (0 = reset)
i_ex_vld  in  1  EX/MEM holds a valid instruction
o_ex_rdy  out  1  stage accepts an instruction this cycle
i_ex_pc  in  32  instruction PC
i_ex_inst  in  32  instruction word
i_ex_alu_data  in  32  ALU result / effective address
i_ex_rs2_data  in  32  store data
i_ex_lsu_rden  in  1  load
i_ex_lsu_wren  in  1  store
i_ex_funct3  in  3  access size/sign
i_ex_wb_sel  in  2  writeback mux select (passed through)
i_ex_rd_wren  in  1  register write enable (passed through)
o_dmem_req  out  1  memory request
o_dmem_we  out  1  1 = write
o_dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
o_dmem_wdata  out  32  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  32  read word
o_wb_vld  out  1  WB register valid (one cycle per retired instruction)
o_wb_pc_add4  out  32  i_ex_pc + PC_INC
o_wb_alu_data  out  32  registered ALU result
o_wb_ld_data  out  32  extended load data
o_wb_inst  out  32  registered instruction
o_wb_wb_sel  out  2  registered wb_sel
o_wb_rd_wren  out  1  registered rd_wren, forced 0 on fault
o_mem_rd_addr_fwd  out  5  rd of the instruction currently held in MEM (inst[11:7])
o_mem_stall  out  1  state != IDLE
o_misalign  out  1  one-cycle pulse: misaligned or illegal access
o_timeout  out  1  one-cycle pulse: access aborted

Behaviour:
- Reset (i_reset=0 at a rising edge): state=IDLE, timeout counter=0, all registered outputs 0. o_ex_rdy=0 while i_reset=0. Any outstanding access is abandoned and produces no o_wb_vld.
- States:
  - IDLE: o_ex_rdy=1. Accept when i_ex_vld=1; capture pc, inst, alu, rs2, funct3, control, and precomputed be/wdata.
  - REQ: o_dmem_req=1, o_dmem_* stable until i_dmem_gnt.
  - RESP: waits for i_dmem_rvalid.
- Transitions from IDLE on accept:
  - No memory op: WB register loads next edge, o_wb_vld=1 for one cycle, stays IDLE (throughput 1/cycle).
  - Memory op, aligned and legal: -> REQ.
  - Misaligned or illegal: no request issued. WB loads with rd_wren=0, ld_data=0. o_misalign=1 and o_wb_vld=1 in the same cycle. Stays IDLE.
- Transitions from REQ and RESP:
  - REQ, gnt=1 and store: -> IDLE; WB loads on that edge.
  - REQ, gnt=1 and load: -> RESP.
  - RESP, rvalid=1: extend data, WB loads, -> IDLE.
  - i_dmem_rvalid outside RESP is ignored.
- Alignment rules:
  - funct3 000/100: any address.
  - funct3 001/101: addr[0]=0.
  - funct3 010: addr[1:0]=00.
  - Illegal: load with funct3 in {011, 110, 111}; store with funct3 > 010; rden and wren both set.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 0011 << {addr[1],1'b0}, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111.
  - For loads: o_dmem_be=1111, o_dmem_we=0.
- Load data: select the byte/half from rdata by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/RESP. When it reaches TIMEOUT_CYC with no completion: -> IDLE, WB loads with rd_wren=0 and ld_data=0, o_timeout=1 and o_wb_vld=1 in that cycle. If completion and timeout coincide, completion wins and there is no o_timeout.
- o_mem_stall and o_ex_rdy are combinational from state (o_ex_rdy = ~o_mem_stall & i_reset). Back-to-back loads therefore cost at least 3 cycles each.
- o_wb_* other than o_wb_vld hold their value when o_wb_vld=0.
- o_mem_rd_addr_fwd reflects the held instruction while stalled, and i_ex_inst[11:7] in IDLE.

Test Plan:
- ALU op, pc=0x100, alu=0x55, i_ex_vld=1 -> next cycle o_wb_vld=1, o_wb_pc_add4=0x104, o_wb_alu_data=0x55, o_ex_rdy stays 1.
- LB addr=0x203, gnt after 2 cycles, rvalid 1 cycle later with rdata=0x80FFFFFF -> o_dmem_addr=0x200, o_wb_ld_data=0xFFFFFF80, o_mem_stall high 4 cycles.
- SH addr=0x102, rs2=0x1234ABCD, gnt immediate -> o_dmem_be=1100, o_dmem_wdata=0xABCDABCD, o_dmem_we=1, o_wb_vld 1 cycle after gnt.
- LW addr=0x101 -> no o_dmem_req, o_misalign=1, o_wb_vld=1, o_wb_rd_wren=0.
- TIMEOUT_CYC=8, LHU with gnt but rvalid never asserted -> o_timeout pulses after 8 stalled cycles, o_wb_rd_wren=0, back to IDLE.
- i_reset=0 during RESP, then rvalid -> rvalid ignored, no o_wb_vld, all outputs 0, o_ex_rdy=1 the first cycle after reset is released.
